// File: rtl/ball_controller.sv
// Pong/squash ball controller: serves, moves the ball one position every STEP_CYCLES,
// resolves player returns inside the hit windows and signals misses.
module ball_controller #(
    parameter int NUM_POS     = 16,
    parameter int STEP_CYCLES = 4,
    parameter int HIT_WINDOW  = 2,
    parameter int MISS_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_game,
    input  logic                       squash_en,
    input  logic                       return_a,
    input  logic                       return_b,
    output logic                       hittable_a,
    output logic                       hittable_b,
    output logic [$clog2(NUM_POS)-1:0] ball_pos,
    output logic                       ball_dir,
    output logic                       miss_a,
    output logic                       miss_b,
    output logic                       rally_active
);
    localparam int PW   = $clog2(NUM_POS);
    localparam int TMAX = (STEP_CYCLES > MISS_CYCLES) ? STEP_CYCLES : MISS_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0] POS_LAST = PW'(NUM_POS - 1);
    localparam logic [PW-1:0] WIN_B    = PW'(NUM_POS - HIT_WINDOW);
    localparam logic [PW-1:0] WIN_A    = PW'(HIT_WINDOW - 1);
    localparam logic [TW-1:0] STEP_RLD = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] MISS_RLD = TW'(MISS_CYCLES - 1);
    localparam logic          PLAYER_A = 1'b0;
    localparam logic          PLAYER_B = 1'b1;

    typedef enum logic [2:0] {IDLE, SERVE, TO_B, TO_A, MISS} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          dir_q, dir_d;
    logic          server_q, server_d;
    logic          striker_q, striker_d;
    logic          squash_q, squash_d;
    logic          miss_a_q, miss_a_d;
    logic          miss_b_q, miss_b_d;
    logic          hit_a, hit_b, expire, loser;

    // Hit windows depend only on registered state, so outputs never combinationally follow inputs.
    always_comb begin
        hittable_a = 1'b0;
        hittable_b = 1'b0;
        case (state_q)
            SERVE: begin
                hittable_a = (server_q == PLAYER_A);
                hittable_b = (server_q == PLAYER_B);
            end
            TO_B: hittable_b = !squash_q && (pos_q >= WIN_B);
            TO_A: if (pos_q <= WIN_A) begin
                hittable_a = squash_q ? (striker_q == PLAYER_A) : 1'b1;
                hittable_b = squash_q && (striker_q == PLAYER_B);
            end
            default: ;
        endcase
    end

    assign hit_a  = return_a && hittable_a;
    assign hit_b  = return_b && hittable_b;
    assign expire = (timer_q == '0);
    assign loser  = squash_q ? striker_q : PLAYER_A;

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        timer_d   = timer_q;
        dir_d     = dir_q;
        server_d  = server_q;
        striker_d = striker_q;
        squash_d  = squash_q;
        miss_a_d  = 1'b0;
        miss_b_d  = 1'b0;
        if (!start_game) begin
            state_d   = IDLE;
            pos_d     = '0;
            timer_d   = '0;
            dir_d     = 1'b0;
            server_d  = PLAYER_A;
            striker_d = PLAYER_A;
            squash_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = SERVE;
                    squash_d  = squash_en;
                    server_d  = PLAYER_A;
                    striker_d = PLAYER_A;
                    pos_d     = '0;
                    dir_d     = 1'b0;
                end
                SERVE: if (hit_a || hit_b) begin
                    timer_d = STEP_RLD;
                    if (squash_q || server_q == PLAYER_A) begin
                        state_d = TO_B;
                        dir_d   = 1'b0;
                    end else begin
                        state_d = TO_A;
                        dir_d   = 1'b1;
                    end
                end
                TO_B: begin
                    if (hit_b) begin
                        state_d = TO_A;
                        dir_d   = 1'b1;
                        timer_d = STEP_RLD;
                    end else if (expire) begin
                        timer_d = STEP_RLD;
                        if (pos_q != POS_LAST) begin
                            pos_d = pos_q + PW'(1);
                        end else if (squash_q) begin
                            state_d = TO_A;
                            dir_d   = 1'b1;
                        end else begin
                            state_d  = MISS;
                            miss_b_d = 1'b1;
                            server_d = PLAYER_B;
                            timer_d  = MISS_RLD;
                        end
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                TO_A: begin
                    if (hit_a || hit_b) begin
                        state_d   = TO_B;
                        dir_d     = 1'b0;
                        timer_d   = STEP_RLD;
                        striker_d = squash_q ? ~striker_q : striker_q;
                    end else if (expire) begin
                        timer_d = STEP_RLD;
                        if (pos_q != '0) begin
                            pos_d = pos_q - PW'(1);
                        end else begin
                            state_d   = MISS;
                            miss_a_d  = (loser == PLAYER_A);
                            miss_b_d  = (loser == PLAYER_B);
                            server_d  = loser;
                            striker_d = loser;
                            timer_d   = MISS_RLD;
                        end
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                MISS: begin
                    if (expire) begin
                        // Only a tennis B serve starts from the far end.
                        state_d = SERVE;
                        pos_d   = (!squash_q && server_q == PLAYER_B) ? POS_LAST : '0;
                        dir_d   = !squash_q && server_q == PLAYER_B;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pos_q     <= '0;
            timer_q   <= '0;
            dir_q     <= 1'b0;
            server_q  <= PLAYER_A;
            striker_q <= PLAYER_A;
            squash_q  <= 1'b0;
            miss_a_q  <= 1'b0;
            miss_b_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            timer_q   <= timer_d;
            dir_q     <= dir_d;
            server_q  <= server_d;
            striker_q <= striker_d;
            squash_q  <= squash_d;
            miss_a_q  <= miss_a_d;
            miss_b_q  <= miss_b_d;
        end
    end

    assign ball_pos     = pos_q;
    assign ball_dir     = dir_q;
    assign miss_a       = miss_a_q;
    assign miss_b       = miss_b_q;
    assign rally_active = (state_q == TO_B) || (state_q == TO_A);

endmodule

// File: tb/tb_ball_controller.sv
// Directed bench for ball_controller: a per-cycle rules model plus hand-computed checkpoints.
module tb_ball_controller;
    localparam int N    = 16;
    localparam int STEP = 4;
    localparam int HW   = 2;
    localparam int MC   = 8;

    localparam int P_IDLE = 0, P_SERVE = 1, P_FLY_B = 2, P_FLY_A = 3, P_HOLD = 4;

    logic                 clk = 1'b0;
    logic                 rst, start_game, squash_en, return_a, return_b;
    logic                 hittable_a, hittable_b, ball_dir, miss_a, miss_b, rally_active;
    logic [$clog2(N)-1:0] ball_pos;

    int vectors     = 0;
    int miscompares = 0;
    int n;

    ball_controller #(.NUM_POS(N), .STEP_CYCLES(STEP), .HIT_WINDOW(HW), .MISS_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .start_game(start_game), .squash_en(squash_en),
        .return_a(return_a), .return_b(return_b),
        .hittable_a(hittable_a), .hittable_b(hittable_b), .ball_pos(ball_pos),
        .ball_dir(ball_dir), .miss_a(miss_a), .miss_b(miss_b), .rally_active(rally_active)
    );

    always #5 clk = ~clk;

    // Rules model: phase, position, cycles spent in the current step/hold, server and striker (0=A,1=B).
    int m_ph, m_pos, m_cnt, m_srv, m_strk;
    bit m_sq, m_dir, m_ma, m_mb, m_ha, m_hb;

    function automatic bit m_hit(input int who);
        case (m_ph)
            P_SERVE: return who == m_srv;
            P_FLY_B: return !m_sq && who == 1 && m_pos >= N - HW;
            P_FLY_A: return m_pos < HW && (m_sq ? who == m_strk : who == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic m_clear();
        m_ph = P_IDLE; m_pos = 0; m_cnt = 0; m_srv = 0; m_strk = 0;
        m_sq = 0; m_dir = 0; m_ma = 0; m_mb = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_clear();
        else begin
            m_ha = return_a && m_hit(0);
            m_hb = return_b && m_hit(1);
            m_ma = 0; m_mb = 0;
            if (!start_game) m_clear();
            else case (m_ph)
                P_IDLE: begin
                    m_ph = P_SERVE; m_sq = squash_en; m_srv = 0; m_strk = 0; m_pos = 0; m_dir = 0;
                end
                P_SERVE: if (m_ha || m_hb) begin
                    m_cnt = 0;
                    if (m_sq || m_srv == 0) begin m_ph = P_FLY_B; m_dir = 0; end
                    else begin m_ph = P_FLY_A; m_dir = 1; end
                end
                P_FLY_B: if (m_hb) begin
                    m_ph = P_FLY_A; m_dir = 1; m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == STEP) begin
                        m_cnt = 0;
                        if (m_pos < N - 1) m_pos++;
                        else if (m_sq) begin m_ph = P_FLY_A; m_dir = 1; end
                        else begin m_ph = P_HOLD; m_mb = 1; m_srv = 1; end
                    end
                end
                P_FLY_A: if (m_ha || m_hb) begin
                    m_ph = P_FLY_B; m_dir = 0; m_cnt = 0;
                    if (m_sq) m_strk = 1 - m_strk;
                end else begin
                    m_cnt++;
                    if (m_cnt == STEP) begin
                        m_cnt = 0;
                        if (m_pos > 0) m_pos--;
                        else begin
                            m_ph = P_HOLD;
                            m_srv = m_sq ? m_strk : 0;
                            m_strk = m_srv;
                            if (m_srv == 1) m_mb = 1; else m_ma = 1;
                        end
                    end
                end
                P_HOLD: begin
                    m_cnt++;
                    if (m_cnt == MC) begin
                        m_cnt = 0; m_ph = P_SERVE;
                        m_pos = (!m_sq && m_srv == 1) ? N - 1 : 0;
                        m_dir = !m_sq && m_srv == 1;
                    end
                end
                default: m_clear();
            endcase
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("m_hittable_a", int'(hittable_a), int'(m_hit(0)));
        chk("m_hittable_b", int'(hittable_b), int'(m_hit(1)));
        chk("m_ball_pos", int'(ball_pos), m_pos);
        chk("m_ball_dir", int'(ball_dir), int'(m_dir));
        chk("m_miss_a", int'(miss_a), int'(m_ma));
        chk("m_miss_b", int'(miss_b), int'(m_mb));
        chk("m_rally", int'(rally_active), int'(m_ph == P_FLY_A || m_ph == P_FLY_B));
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_miss(input int budget, output int cnt);
        cnt = 0;
        while (cnt < budget) begin
            tick(1);
            cnt++;
            if (miss_a || miss_b) break;
        end
    endtask

    initial begin
        rst = 1; start_game = 0; squash_en = 0; return_a = 0; return_b = 0;
        fork
            forever begin @(negedge clk); compare_all(); end
        join_none
        repeat (2) @(posedge clk);
        #1 rst = 0;
        tick(2);
        chk("reset_pos", int'(ball_pos), 0);
        chk("reset_rally", int'(rally_active), 0);
        chk("reset_hit_a", int'(hittable_a), 0);

        // Tennis: A serves, B returns with both strobes high, A misses.
        start_game = 1; tick(1);
        chk("serve_hit_a", int'(hittable_a), 1);
        chk("serve_hit_b", int'(hittable_b), 0);
        chk("serve_pos", int'(ball_pos), 0);
        return_b = 1; tick(1); return_b = 0;
        chk("serve_ignore_b", int'(rally_active), 0);
        return_a = 1; tick(1); return_a = 0;
        chk("rally_on", int'(rally_active), 1);
        chk("dir_to_b", int'(ball_dir), 0);
        tick(52);
        chk("pos13", int'(ball_pos), 13);
        chk("pos13_no_hit_b", int'(hittable_b), 0);
        tick(4);
        chk("pos14", int'(ball_pos), 14);
        chk("pos14_hit_b", int'(hittable_b), 1);
        return_a = 1; return_b = 1; tick(1); return_a = 0; return_b = 0;
        chk("both_dir", int'(ball_dir), 1);
        chk("both_hit_b_low", int'(hittable_b), 0);
        chk("both_pos", int'(ball_pos), 14);
        wait_miss(100, n);
        chk("miss_a_latency", n, 60);
        chk("miss_a_pulse", int'(miss_a), 1);
        chk("miss_a_not_b", int'(miss_b), 0);
        tick(1);
        chk("miss_a_width", int'(miss_a), 0);
        tick(6);
        chk("hold_no_hit", int'(hittable_a), 0);
        tick(1);
        chk("reserve_a", int'(hittable_a), 1);
        chk("reserve_pos", int'(ball_pos), 0);

        // Tennis: 60-cycle flight, hit coincident with expiry at 15, B misses and serves.
        return_a = 1; tick(1); return_a = 0;
        tick(60);
        chk("pos15_at_60", int'(ball_pos), 15);
        chk("pos15_hit_b", int'(hittable_b), 1);
        tick(3);
        return_b = 1; tick(1); return_b = 0;
        chk("edge_hit_dir", int'(ball_dir), 1);
        chk("edge_hit_no_miss", int'(miss_b), 0);
        chk("edge_hit_pos", int'(ball_pos), 15);
        tick(56);
        chk("pos1", int'(ball_pos), 1);
        chk("pos1_hit_a", int'(hittable_a), 1);
        return_a = 1; tick(1); return_a = 0;
        chk("a_return_dir", int'(ball_dir), 0);
        wait_miss(100, n);
        chk("miss_b_latency", n, 60);
        chk("miss_b_pulse", int'(miss_b), 1);
        tick(8);
        chk("serve_b_pos", int'(ball_pos), 15);
        chk("serve_b_hit_b", int'(hittable_b), 1);
        chk("serve_b_hit_a", int'(hittable_a), 0);
        chk("serve_b_dir", int'(ball_dir), 1);
        return_a = 1; tick(1); return_a = 0;
        chk("serve_b_ignore_a", int'(rally_active), 0);
        return_b = 1; tick(1); return_b = 0;
        chk("serve_b_rally", int'(rally_active), 1);
        tick(5);
        start_game = 0; tick(1);
        chk("abort_rally", int'(rally_active), 0);
        chk("abort_pos", int'(ball_pos), 0);
        chk("abort_dir", int'(ball_dir), 0);
        chk("abort_hit_b", int'(hittable_b), 0);

        // Squash: wall bounce, striker alternation, striker B misses and serves from 0.
        squash_en = 1; start_game = 1; tick(1);
        chk("sq_serve_hit_a", int'(hittable_a), 1);
        squash_en = 0;
        return_a = 1; tick(1); return_a = 0;
        tick(56);
        chk("sq_pos14", int'(ball_pos), 14);
        chk("sq_no_hit_b", int'(hittable_b), 0);
        tick(8);
        chk("sq_bounce_dir", int'(ball_dir), 1);
        chk("sq_bounce_pos", int'(ball_pos), 15);
        chk("sq_bounce_no_miss", int'(miss_b), 0);
        tick(56);
        chk("sq_pos1", int'(ball_pos), 1);
        chk("sq_hit_a", int'(hittable_a), 1);
        chk("sq_no_hit_b_a", int'(hittable_b), 0);
        return_b = 1; tick(1); return_b = 0;
        chk("sq_ignore_b", int'(ball_dir), 1);
        return_a = 1; tick(1); return_a = 0;
        chk("sq_a_return", int'(ball_dir), 0);
        tick(116);
        chk("sq2_pos1", int'(ball_pos), 1);
        chk("sq2_hit_b", int'(hittable_b), 1);
        chk("sq2_no_hit_a", int'(hittable_a), 0);
        wait_miss(50, n);
        chk("sq_miss_latency", n, 8);
        chk("sq_miss_b", int'(miss_b), 1);
        chk("sq_miss_not_a", int'(miss_a), 0);
        tick(8);
        chk("sq_serve_b_hit", int'(hittable_b), 1);
        chk("sq_serve_b_pos", int'(ball_pos), 0);
        return_b = 1; tick(1); return_b = 0;
        tick(10);
        chk("sq_pos2", int'(ball_pos), 2);

        // Asynchronous reset mid-rally, then hold in IDLE until start_game.
        #2 rst = 1;
        #1;
        chk("arst_rally", int'(rally_active), 0);
        chk("arst_pos", int'(ball_pos), 0);
        chk("arst_dir", int'(ball_dir), 0);
        chk("arst_hit_b", int'(hittable_b), 0);
        start_game = 0;
        @(posedge clk); #1 rst = 0;
        tick(2);
        chk("idle_hold_rally", int'(rally_active), 0);
        chk("idle_hold_hit_a", int'(hittable_a), 0);
        start_game = 1; tick(1);
        chk("restart_hit_a", int'(hittable_a), 1);
        chk("restart_pos", int'(ball_pos), 0);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ball_controller.md
BALL_CONTROLLER -- requirements
Module: ball_controller

Interface
- REQ-001 Parameter NUM_POS, default 16: court positions, ball_pos range 0..NUM_POS-1; A end = 0, B/wall end = NUM_POS-1.
- REQ-002 Parameter STEP_CYCLES, default 4: clock cycles per ball step.
- REQ-003 Parameter HIT_WINDOW, default 2: positions at each end where the ball is hittable.
- REQ-004 Parameter MISS_CYCLES, default 8: hold cycles in MISS before the next serve.
- REQ-005 clk  input  1  single system clock, rising edge.
- REQ-006 rst  input  1  asynchronous, active-high reset.
- REQ-007 start_game  input  1  level; 1 = game running, 0 = return to IDLE.
- REQ-008 squash_en  input  1  level; 1 = squash mode (wall at NUM_POS-1), sampled only in IDLE.
- REQ-009 return_a / return_b  input  1 each  player hit strobes (level; edge detection is the player's job).
- REQ-010 hittable_a / hittable_b  output  1 each  ball is in that player's hit window.
- REQ-011 ball_pos  output  $clog2(NUM_POS)  current ball position.
- REQ-012 ball_dir  output  1  0 = moving toward B/wall, 1 = moving toward A.
- REQ-013 miss_a / miss_b  output  1 each  one-cycle pulse: that player lost the point.
- REQ-014 rally_active  output  1  high in TO_B/TO_A states.

Function
- REQ-015 States: IDLE, SERVE, TO_B, TO_A, MISS; state, position, step timer and striker are registers.
- REQ-016 Any state with start_game=0 -> IDLE next cycle; all outputs return to reset values.
- REQ-017 IDLE with start_game=1 -> SERVE; latch squash_en into mode; server = A.
- REQ-018 SERVE: ball_pos = server end (A: 0, B: NUM_POS-1); server's hittable held high; server's return -> TO_B (A) or TO_A (B), step timer reloaded; other player's return ignored.
- REQ-019 Squash mode: server is always serve from position 0; server/striker = player who lost the last point (A for the first serve).
- REQ-020 Tennis mode: server = player who lost the last point.
- REQ-021 Moving: step timer counts STEP_CYCLES cycles; on expiry ball_pos steps by 1 toward the target end and the timer reloads.
- REQ-022 Tennis: hittable_b = state TO_B and ball_pos >= NUM_POS-HIT_WINDOW; hittable_a = state TO_A and ball_pos <= HIT_WINDOW-1.
- REQ-023 Tennis: return_b while hittable_b -> TO_A next cycle, position unchanged, timer reloaded; same for A -> TO_B.
- REQ-024 Squash: on reaching NUM_POS-1 in TO_B, the next step expiry reverses to TO_A automatically (wall bounce, no hittable).
- REQ-025 Squash: in TO_A, only the current striker's hittable asserts; its valid return -> TO_B and striker toggles; the non-striker's return is ignored.
- REQ-026 Miss: ball at the end position (0 in TO_A, NUM_POS-1 in tennis TO_B), step timer expires with no valid return -> pulse miss_x for the responsible player for 1 cycle, enter MISS.
- REQ-027 A return in the same cycle as the timer expiry at the end counts as a hit, not a miss.
- REQ-028 return_a and return_b high together: only the expected player's strobe is honored.
- REQ-029 A return while that player's hittable is low has no effect.
- REQ-030 MISS: ball_pos frozen, hittables low for MISS_CYCLES cycles, then SERVE.
- REQ-031 Registers update only on rising clk, except asynchronous reset.

Reset
- REQ-032 rst=1 asynchronously forces: state IDLE, ball_pos 0, ball_dir 0, all hittable/miss/rally_active outputs 0, timers 0, server A.
- REQ-033 Reset asserted mid-rally aborts it immediately; after release the block stays in IDLE until start_game is sampled high.

Verification
- REQ-034 Tennis serve: rst, start_game=1, squash_en=0 -> SERVE, ball_pos 0, hittable_a=1; pulse return_a -> rally_active=1, ball_pos reaches 15 after 60 cycles, hittable_b=1 at pos 14-15.
- REQ-035 Tennis return: return_b at pos 14 -> ball_dir=1 next cycle, hittable_b=0; no further returns -> miss_a pulses once when the step timer expires at pos 0, then MISS for 8 cycles, then SERVE with server A.
- REQ-036 Squash: squash_en=1, A serves -> automatic bounce at pos 15, only hittable_a at pos 0-1; return_b there is ignored; return_a -> striker B; the next approach raises only hittable_b.
- REQ-037 Boundary: return_b coincident with timer expiry at pos 15 -> hit (ball_dir=1), no miss_b; return_a and return_b simultaneously in the B window -> only B honored.
- REQ-038 Abort: start_game=0 mid-rally -> IDLE next cycle, all outputs 0; rst pulse mid-rally -> immediate reset values without waiting for a clock edge.
